stream_merger_dp_ram: RTL and testbench

Receive-side counterpart of the 64-to-2×32 stream splitter: joins two 32-bit AXI-Stream lanes into one 64-bit word, buffers words in a circular dual-port RAM, and replays them as a 64-bit AXI-Stream in framed bursts of BURST_LEN beats separated by GAP_CYCLES idle cycles. It sits where the two 32-bit lanes re-enter the 64-bit datapath and restores the original word pairing (lane 0 = low half).

---
 rtl/stream_merger_dp_ram.sv | 171 +++++++++++++++++
 tb/tb_stream_merger_dp_ram.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_merger_dp_ram.sv
// rtl/stream_merger_dp_ram.sv - joins two 32-bit lanes into 64-bit words, buffers them in a circular RAM, replays in framed bursts
// Optional feature macro: STREAM_MERGER_TLAST_EN (registered m_tlast on the last beat of each burst).
module stream_merger_dp_ram #(
   parameter int BURST_LEN  = 3276,
   parameter int GAP_CYCLES = 1172,
   parameter int DEPTH      = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                s0_tdata,
   input  logic                       s0_tvalid,
   output logic                       s0_tready,
   input  logic [31:0]                s1_tdata,
   input  logic                       s1_tvalid,
   output logic                       s1_tready,
   output logic [63:0]                m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic [$clog2(DEPTH):0]     fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0]   BL_W    = 16'(BURST_LEN);
   localparam logic [15:0]   BL_M1   = 16'(BURST_LEN - 1);
   localparam logic [15:0]   GAP_M1  = 16'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   fill_q, fill_d;
   logic [15:0]     issued_q, issued_d;
   logic [15:0]     gap_cnt_q, gap_cnt_d;
   logic            m_tvalid_q, m_tvalid_d;
   logic [63:0]     m_tdata_q, m_tdata_d;
   logic            m_tlast_q, m_tlast_d;

   logic [63:0]     mem [DEPTH];
   logic [63:0]     rd_word;
   logic            full, empty, wr_en, load, hs;

   // full/empty come from the registered count only, so a same-cycle read never frees space for a write
   assign full  = (fill_q == DEPTH_W);
   assign empty = (fill_q == '0);

   // lanes are only ever taken as a pair; each ready depends on the other lane's valid
   assign s0_tready = s1_tvalid && !full && !rst;
   assign s1_tready = s0_tvalid && !full && !rst;
   assign wr_en     = s0_tvalid && s1_tvalid && !full && !rst;

   assign hs   = m_tvalid_q && m_tready;
   assign load = (state_q == S_BURST) && !empty && (issued_q < BL_W) && (!m_tvalid_q || m_tready);

   assign m_tdata    = m_tdata_q;
   assign m_tvalid   = m_tvalid_q;
   assign m_tlast    = m_tlast_q;
   assign fill_level = fill_q;

   // buffer write port; contents need no reset since the pointers define what is valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= {s1_tdata, s0_tdata};
      end
   end

   // buffer read port feeds the output register directly on a load
   always_comb begin
      rd_word = mem[rd_ptr_q];
   end

   // pointer and occupancy bookkeeping
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (load) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, load})
         2'b10:   fill_d = fill_q + CW'(1);
         2'b01:   fill_d = fill_q - CW'(1);
         default: fill_d = fill_q;
      endcase
   end

   // burst/gap framing and output register next-state
   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      gap_cnt_d  = gap_cnt_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      case (state_q)
         S_IDLE: begin
            issued_d   = '0;
            gap_cnt_d  = '0;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            if (!empty) begin
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (load) begin
               m_tdata_d  = rd_word;
               m_tvalid_d = 1'b1;
               issued_d   = issued_q + 16'd1;
`ifdef STREAM_MERGER_TLAST_EN
               m_tlast_d  = (issued_q == BL_M1);
`else
               m_tlast_d  = 1'b0;
`endif
            end else if (hs) begin
               m_tvalid_d = 1'b0;
               m_tlast_d  = 1'b0;
            end
            // the beat being accepted while issued == BURST_LEN is the final one of the burst
            if (hs && (issued_q == BL_W)) begin
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            if (gap_cnt_q == GAP_M1) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // all control state and the output register; reset discards buffered data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         issued_q   <= '0;
         gap_cnt_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         issued_q   <= issued_d;
         gap_cnt_q  <= gap_cnt_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

endmodule

// File: tb/tb_stream_merger_dp_ram.sv
// tb/tb_stream_merger_dp_ram.sv - randomized and directed bench for stream_merger_dp_ram against a behavioural model
module tb_stream_merger_dp_ram;

   localparam int BL = 4;
   localparam int G  = 3;
   localparam int D  = 8;
`ifdef STREAM_MERGER_TLAST_EN
   localparam bit TLAST_ON = 1'b1;
`else
   localparam bit TLAST_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s0_tdata = '0;
   logic        s0_tvalid = 1'b0;
   logic        s0_tready;
   logic [31:0] s1_tdata = '0;
   logic        s1_tvalid = 1'b0;
   logic        s1_tready;
   logic [63:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;
   logic [3:0]  fill_level;

   int n_checks = 0;
   int n_fail   = 0;

   stream_merger_dp_ram #(.BURST_LEN(BL), .GAP_CYCLES(G), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: words queue in order; bursts of BL beats, then G idle cycles plus one IDLE cycle
   int           cyc = 0;
   int           m_fill = 0;
   logic [63:0]  m_q[$];
   logic         m_valid = 1'b0;
   logic [63:0]  m_data = '0;
   logic         m_last = 1'b0;
   int           m_issued = 0;
   bit           m_in_burst = 1'b0;
   int           m_idle_at = -100;
   bit           t_acc, t_hs, t_load;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_fill = 0; m_q.delete(); m_valid = 1'b0; m_data = '0; m_last = 1'b0;
         m_issued = 0; m_in_burst = 1'b0; m_idle_at = -100;
      end else begin
         t_acc  = s0_tvalid && s1_tvalid && (m_fill < D);
         t_hs   = m_valid && m_tready;
         t_load = 1'b0;
         if (m_in_burst) begin
            t_load = (m_fill > 0) && (m_issued < BL) && (!m_valid || m_tready);
            if (t_hs && m_issued == BL) begin
               m_in_burst = 1'b0;
               m_idle_at  = cyc + G;
            end
            if (t_load) begin
               m_data  = m_q.pop_front();
               m_valid = 1'b1;
               m_last  = TLAST_ON && (m_issued == BL - 1);
               m_issued++;
            end else if (t_hs) begin
               m_valid = 1'b0;
               m_last  = 1'b0;
            end
         end else if (cyc >= m_idle_at + 1 && m_fill > 0) begin
            m_in_burst = 1'b1;
            m_issued   = 0;
         end
         if (t_acc) m_q.push_back({s1_tdata, s0_tdata});
         m_fill = m_fill + int'(t_acc) - int'(t_load);
      end
   end

   // handshake monitor used by the directed literal checks
   int dut_hs = 0;
   int dut_last = 0;
   always @(posedge clk) begin
      if (!rst && m_tvalid && m_tready) begin
         dut_hs++;
         if (m_tlast) dut_last++;
      end
   end

   // per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         check("rst_tvalid", m_tvalid, 0);
         check("rst_tdata", m_tdata, 0);
         check("rst_tlast", m_tlast, 0);
         check("rst_fill", fill_level, 0);
         check("rst_s0_tready", s0_tready, 0);
         check("rst_s1_tready", s1_tready, 0);
      end else begin
         check("tvalid", m_tvalid, m_valid);
         if (m_valid) check("tdata", m_tdata, m_data);
         check("tlast", m_tlast, m_last);
         check("fill_level", fill_level, m_fill);
         check("s0_tready", s0_tready, s1_tvalid && (m_fill < D));
         check("s1_tready", s1_tready, s0_tvalid && (m_fill < D));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 300;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
      while ((fill_level != 0 || m_tvalid) && budget > 0) begin
         tick();
         budget--;
      end
      n_checks++;
      if (budget == 0) begin
         n_fail++;
         $display("FAIL %s_drain_timeout: fill %0d tvalid %0d not drained", name, fill_level, m_tvalid);
      end
   endtask

   // single pair with latency pinned by hand
   task automatic single_pair(input string name);
      m_tready = 1'b1;
      s0_tdata = 32'h11111111; s1_tdata = 32'h22222222;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1;
      #1 check({name, "_s0_tready"}, s0_tready, 1);
      @(posedge clk); #2;                       // edge T
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      @(negedge clk);
      check({name, "_fill_T"}, fill_level, 1);
      check({name, "_valid_T"}, m_tvalid, 0);
      @(posedge clk); @(negedge clk);           // after T+1
      check({name, "_valid_T1"}, m_tvalid, 0);
      @(posedge clk); @(negedge clk);           // after T+2
      check({name, "_valid_T2"}, m_tvalid, 1);
      check({name, "_data_T2"}, m_tdata, 64'h2222222211111111);
      @(posedge clk); @(negedge clk);
      check({name, "_valid_T3"}, m_tvalid, 0);
      #2;
   endtask

   initial begin
      int h0, l0;
      tick(); tick();
      check("reset_fill_lit", fill_level, 0);
      rst = 1'b0;

      // single pair latency
      single_pair("single");

      // ten pairs back to back through bursts of four with gaps
      do_reset();
      h0 = dut_hs; l0 = dut_last;
      m_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s0_tdata = $urandom(); s1_tdata = $urandom();
         s0_tvalid = 1'b1; s1_tvalid = 1'b1;
         tick();
      end
      drain("ten");
      check("ten_beats", dut_hs - h0, 10);
      check("ten_tlast_count", dut_last - l0, TLAST_ON ? 2 : 0);

      // fill to capacity with output stalled
      do_reset();
      h0 = dut_hs;
      m_tready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         s0_tdata = $urandom(); s1_tdata = $urandom();
         s0_tvalid = 1'b1; s1_tvalid = 1'b1;
         tick();
      end
      @(negedge clk);
      check("full_fill", fill_level, 8);
      check("full_s0_tready", s0_tready, 0);
      check("full_s1_tready", s1_tready, 0);
      check("full_tvalid", m_tvalid, 1);
      #2;
      drain("full");
      check("full_beats", dut_hs - h0, 9);

      // lone lane waits for its partner
      do_reset();
      m_tready = 1'b0;
      s0_tdata = 32'hA5A5A5A5; s1_tdata = 32'h5A5A5A5A;
      s0_tvalid = 1'b1; s1_tvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("lone_s0_tready", s0_tready, 0);
         check("lone_fill", fill_level, 0);
      end
      s1_tvalid = 1'b1;
      tick();
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      check("lone_fill_after", fill_level, 1);
      drain("lone");

      // toggling downstream ready
      do_reset();
      h0 = dut_hs;
      for (int i = 0; i < 400; i++) begin
         m_tready = i[0];
         s0_tdata = $urandom(); s1_tdata = $urandom();
         s0_tvalid = ($urandom_range(0, 9) < 7); s1_tvalid = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain("toggle");

      // fully random traffic
      for (int i = 0; i < 2000; i++) begin
         m_tready = ($urandom_range(0, 3) != 0);
         s0_tdata = $urandom(); s1_tdata = $urandom();
         s0_tvalid = $urandom_range(0, 1) == 1; s1_tvalid = $urandom_range(0, 1) == 1;
         tick();
      end
      drain("random");

      // reset in the middle of a burst
      do_reset();
      m_tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s0_tdata = $urandom(); s1_tdata = $urandom();
         s0_tvalid = 1'b1; s1_tvalid = 1'b1;
         tick();
      end
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      @(negedge clk);
      check("midrst_fill_before", fill_level, 5);
      check("midrst_tvalid_before", m_tvalid, 1);
      @(posedge clk); #2;
      rst = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b1;
      #1;
      check("midrst_fill", fill_level, 0);
      check("midrst_tvalid", m_tvalid, 0);
      check("midrst_s0_tready", s0_tready, 0);
      check("midrst_s1_tready", s1_tready, 0);
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      tick();
      rst = 1'b0;
      single_pair("after_rst");
      drain("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1);
   end

endmodule
